ex_sequencer: RTL and testbench
===============================

EX_SEQUENCER -- requirements
Module: ex_sequencer

Interface
REQ-001 Parameter MAX_STEPS, default 6, maximum execute steps per instruction; legal range 4..16.
REQ-002 Parameter IDX_W, default $clog2(MAX_STEPS), width of the step index.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ctl_op  input  ctl_op_t  decoded control op; stable for the whole instruction.
REQ-006 decoded_alu_op  input  alu_op_t  ALU op from the decoder.
REQ-007 cond_met  input  1  flag condition for conditional ops is true.
REQ-008 mem_wait  input  1  memory not ready; stall request.
REQ-009 wake  input  1  interrupt/wake request while halted.
REQ-010 alu_op  output  alu_op_t  equals decoded_alu_op.
REQ-011 strobes  output  ctl_strobe_t  inc_pc, wz_to_pc, mem_to_z, mem_to_w, mem_to_ir, mem_to_r8, capture_alu_res, r8_to_alu_op1, update_flags, r8_to_mem, z_to_mem.
REQ-012 addr_sel  output  addr_sel_t  bus address source (PC, GP16, WZ, FF_C, NONE).
REQ-013 step_idx  output  IDX_W  current execute step.
REQ-014 last  output  1  current cycle is the final step (fetch cycle).
REQ-015 halt  output  1  core halted, registered.

Function
REQ-016 Each ctl_op SHALL map to a sequence of ex_state_t entries plus last_idx; unlisted steps are EX_IDLE; unknown ops use {EX_IDLE}, last_idx 0.
REQ-017 A sequence longer than MAX_STEPS SHALL fail elaboration.
REQ-018 last SHALL be 1 when step_idx >= last_idx, when a conditional check fails (REQ-021), or when step_idx >= MAX_STEPS.
REQ-019 When last=1, mem_to_ir=1 and inc_pc=1, and step_idx SHALL return to 0 on the next edge; otherwise step_idx increments by 1.
REQ-020 Per-state strobes and addr_sel SHALL follow the existing ex_state_t decode (EX_MEM_TO_Z, EX_MEM_TO_W, EX_MEM_WZ_TO_Z, EX_ALU_R8, EX_ALU_LD1, EX_Z_TO_MEM, EX_R8_TO_MEM, EX_A_TO_WZ_MEM, EX_WZ_TO_PC, EX_HALT); default addr_sel is PC.
REQ-021 New state EX_COND_CHK SHALL assert no strobes; if cond_met=0 it forces last=1 (early fetch); if cond_met=1 the sequence continues.
REQ-022 New ops: CTL_JP_CC_A16 = {MEM_TO_Z, MEM_TO_W, COND_CHK, WZ_TO_PC, IDLE}, last_idx 4 (5 cycles taken, 3 not taken); CTL_JR_CC_D8 = {MEM_TO_Z, COND_CHK, ALU_R8 (PC adjust), IDLE}, last_idx 3.
REQ-023 EX_HALT SHALL set halt on the next edge; while halt=1: all strobes 0, addr_sel NONE, last 0, step_idx held at 0.
REQ-024 wake=1 while halt=1 SHALL clear halt on the next edge; the following cycle is a normal step 0 of the current ctl_op. wake while halt=0 is ignored.
REQ-025 halt being set takes priority over wake in the same cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force step_idx=0 and halt=0, including mid-sequence and while halted.
REQ-027 After reset, outputs SHALL be the combinational decode of step 0 of the presented ctl_op.

Configuration
REQ-028 Macro SEQ_STALL_EN defined: mem_wait=1 holds step_idx and halt, forces all strobes that write state (inc_pc, wz_to_pc, mem_to_*, capture_alu_res, update_flags, r8_to_mem, z_to_mem) to 0, and keeps addr_sel and last at their unstalled values.
REQ-029 Macro SEQ_STALL_EN undefined: mem_wait port is present and ignored.

Structure
REQ-030 ex_state_t (including EX_COND_CHK), ctl_op_t (including the new ops), ctl_strobe_t and addr_sel_t SHALL live in sm83_pkg.
REQ-031 The op-to-sequence table SHALL be the combinational sub-module ex_seq_rom (ctl_op, step_idx -> state, last_idx); counter, halt and stall logic stay in ex_sequencer.

Verification
REQ-032 CTL_LD_R8_D8: step 0 mem_to_z+inc_pc, step 1 capture_alu_res+mem_to_ir+inc_pc, last=1, then step_idx=0.
REQ-033 CTL_JP_CC_A16 with cond_met=0: step 2 last=1 with fetch, step_idx 0 next; with cond_met=1: wz_to_pc at step 3 with addr_sel NONE, fetch at step 4.
REQ-034 CTL_HALT, then wake held low 10 cycles: halt=1 with all strobes 0; wake=1 gives halt=0 next edge, then mem_to_ir=1.
REQ-035 SEQ_STALL_EN, CTL_LDPTR_A_A16, mem_wait=1 for 3 cycles at step 1: step_idx stays 1, mem_to_w=0, addr_sel PC; resumes with 4-cycle total plus 3 stall cycles.
REQ-036 rst_n pulsed low at step 2 of CTL_JP_A16 and during halt: step_idx=0 and halt=0 immediately.
REQ-037 MAX_STEPS=4 build with CTL_JP_CC_A16 in table: elaboration error.

Source files
------------

// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 execute-sequencer types and the op-to-sequence table.
package sm83_pkg;

    typedef enum logic [3:0] {
        CTL_NOP         = 4'd0,
        CTL_LD_R8_D8    = 4'd1,
        CTL_ALU_R8      = 4'd2,
        CTL_LD_HL_R8    = 4'd3,
        CTL_LD_A_A16    = 4'd4,
        CTL_LDPTR_A_A16 = 4'd5,
        CTL_LD_HL_D8    = 4'd6,
        CTL_JP_A16      = 4'd7,
        CTL_JP_CC_A16   = 4'd8,
        CTL_JR_CC_D8    = 4'd9,
        CTL_HALT        = 4'd10
    } ctl_op_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR,
        ALU_OR, ALU_CP, ALU_INC, ALU_DEC, ALU_PASS
    } alu_op_t;

    typedef enum logic [3:0] {
        EX_IDLE, EX_MEM_TO_Z, EX_MEM_TO_W, EX_MEM_WZ_TO_Z, EX_ALU_R8, EX_ALU_LD1,
        EX_Z_TO_MEM, EX_R8_TO_MEM, EX_A_TO_WZ_MEM, EX_WZ_TO_PC, EX_HALT, EX_COND_CHK
    } ex_state_t;

    typedef enum logic [2:0] {
        ADDR_PC, ADDR_GP16, ADDR_WZ, ADDR_FF_C, ADDR_NONE
    } addr_sel_t;

    typedef struct packed {
        logic inc_pc;
        logic wz_to_pc;
        logic mem_to_z;
        logic mem_to_w;
        logic mem_to_ir;
        logic mem_to_r8;
        logic capture_alu_res;
        logic r8_to_alu_op1;
        logic update_flags;
        logic r8_to_mem;
        logic z_to_mem;
    } ctl_strobe_t;

    typedef struct packed {
        logic [4:0] len;
        logic [3:0] last_idx;
        ex_state_t  s0;
        ex_state_t  s1;
        ex_state_t  s2;
        ex_state_t  s3;
        ex_state_t  s4;
    } seq_def_t;

    function automatic seq_def_t seq_def(input ctl_op_t op);
        case (op)
            CTL_NOP:         seq_def = '{5'd1, 4'd0, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE};
            CTL_LD_R8_D8:    seq_def = '{5'd2, 4'd1, EX_MEM_TO_Z, EX_ALU_LD1, EX_IDLE, EX_IDLE, EX_IDLE};
            CTL_ALU_R8:      seq_def = '{5'd1, 4'd0, EX_ALU_R8, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE};
            CTL_LD_HL_R8:    seq_def = '{5'd2, 4'd1, EX_R8_TO_MEM, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE};
            CTL_LD_A_A16:    seq_def = '{5'd4, 4'd3, EX_MEM_TO_Z, EX_MEM_TO_W, EX_MEM_WZ_TO_Z, EX_ALU_LD1, EX_IDLE};
            CTL_LDPTR_A_A16: seq_def = '{5'd4, 4'd3, EX_MEM_TO_Z, EX_MEM_TO_W, EX_A_TO_WZ_MEM, EX_IDLE, EX_IDLE};
            CTL_LD_HL_D8:    seq_def = '{5'd3, 4'd2, EX_MEM_TO_Z, EX_Z_TO_MEM, EX_IDLE, EX_IDLE, EX_IDLE};
            CTL_JP_A16:      seq_def = '{5'd4, 4'd3, EX_MEM_TO_Z, EX_MEM_TO_W, EX_WZ_TO_PC, EX_IDLE, EX_IDLE};
            CTL_JP_CC_A16:   seq_def = '{5'd5, 4'd4, EX_MEM_TO_Z, EX_MEM_TO_W, EX_COND_CHK, EX_WZ_TO_PC, EX_IDLE};
            CTL_JR_CC_D8:    seq_def = '{5'd4, 4'd3, EX_MEM_TO_Z, EX_COND_CHK, EX_ALU_R8, EX_IDLE, EX_IDLE};
            CTL_HALT:        seq_def = '{5'd1, 4'd0, EX_HALT, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE};
            default:         seq_def = '{5'd1, 4'd0, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE};
        endcase
    endfunction

    // Longest sequence over every op encoding, evaluated at elaboration.
    function automatic int longest_seq();
        int       m;
        seq_def_t d;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            d = seq_def(ctl_op_t'(4'(i)));
            if (int'(d.len) > m) m = int'(d.len);
        end
        return m;
    endfunction

endpackage

// File: rtl/ex_seq_rom.sv
// rtl/ex_seq_rom.sv - combinational op/step lookup returning the execute state and last step index.
module ex_seq_rom
    import sm83_pkg::*;
#(
    parameter int MAX_STEPS = 6,
    parameter int IDX_W     = $clog2(MAX_STEPS)
) (
    input  ctl_op_t          ctl_op,
    input  logic [IDX_W-1:0] step_idx,
    output ex_state_t        state,
    output logic [IDX_W-1:0] last_idx
);

    localparam int LONGEST = longest_seq();

    if (MAX_STEPS < 4 || MAX_STEPS > 16) begin : g_bad_range
        $error("ex_seq_rom: MAX_STEPS out of range 4..16");
    end
    if (LONGEST > MAX_STEPS) begin : g_too_long
        $error("ex_seq_rom: a sequence is longer than MAX_STEPS");
    end

    seq_def_t  d;
    ex_state_t pick;

    always_comb begin
        d = seq_def(ctl_op);
        case (int'(step_idx))
            0:       pick = d.s0;
            1:       pick = d.s1;
            2:       pick = d.s2;
            3:       pick = d.s3;
            4:       pick = d.s4;
            default: pick = EX_IDLE;
        endcase
        state    = (int'(step_idx) < int'(d.len)) ? pick : EX_IDLE;
        last_idx = IDX_W'(d.last_idx);
    end

endmodule

// File: rtl/ex_sequencer.sv
// rtl/ex_sequencer.sv - execute step counter, halt/wake and strobe decode; SEQ_STALL_EN enables mem_wait stalls.
module ex_sequencer
    import sm83_pkg::*;
#(
    parameter int MAX_STEPS = 6,
    parameter int IDX_W     = $clog2(MAX_STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  ctl_op_t          ctl_op,
    input  alu_op_t          decoded_alu_op,
    input  logic             cond_met,
    input  logic             mem_wait,
    input  logic             wake,
    output alu_op_t          alu_op,
    output ctl_strobe_t      strobes,
    output addr_sel_t        addr_sel,
    output logic [IDX_W-1:0] step_idx,
    output logic             last,
    output logic             halt
);

    // Only the ALU operand select survives a stall; everything else writes state.
    localparam ctl_strobe_t STALL_KEEP = '{r8_to_alu_op1: 1'b1, default: 1'b0};

    ex_state_t        state;
    logic [IDX_W-1:0] last_idx;
    ctl_strobe_t      dec_strobes;
    addr_sel_t        dec_addr;
    logic             cond_fail;
    logic             seq_last;
    logic             stall;

    ex_seq_rom #(.MAX_STEPS(MAX_STEPS), .IDX_W(IDX_W)) u_rom (
        .ctl_op   (ctl_op),
        .step_idx (step_idx),
        .state    (state),
        .last_idx (last_idx)
    );

`ifdef SEQ_STALL_EN
    assign stall = mem_wait;
`else
    logic unused_mem_wait;
    assign unused_mem_wait = mem_wait;
    assign stall           = 1'b0;
`endif

    assign alu_op = decoded_alu_op;

    always_comb begin
        dec_strobes = '0;
        dec_addr    = ADDR_PC;
        case (state)
            EX_MEM_TO_Z: begin
                dec_strobes.mem_to_z = 1'b1;
                dec_strobes.inc_pc   = 1'b1;
            end
            EX_MEM_TO_W: begin
                dec_strobes.mem_to_w = 1'b1;
                dec_strobes.inc_pc   = 1'b1;
            end
            EX_MEM_WZ_TO_Z: begin
                dec_strobes.mem_to_z = 1'b1;
                dec_addr             = ADDR_WZ;
            end
            EX_ALU_R8: begin
                dec_strobes.r8_to_alu_op1   = 1'b1;
                dec_strobes.capture_alu_res = 1'b1;
                dec_strobes.update_flags    = 1'b1;
            end
            EX_ALU_LD1:   dec_strobes.capture_alu_res = 1'b1;
            EX_Z_TO_MEM: begin
                dec_strobes.z_to_mem = 1'b1;
                dec_addr             = ADDR_GP16;
            end
            EX_R8_TO_MEM: begin
                dec_strobes.r8_to_mem = 1'b1;
                dec_addr              = ADDR_GP16;
            end
            EX_A_TO_WZ_MEM: begin
                dec_strobes.r8_to_mem = 1'b1;
                dec_addr              = ADDR_WZ;
            end
            EX_WZ_TO_PC: begin
                dec_strobes.wz_to_pc = 1'b1;
                dec_addr             = ADDR_NONE;
            end
            default: ;
        endcase
    end

    assign cond_fail = (state == EX_COND_CHK) && !cond_met;
    assign seq_last  = (step_idx >= last_idx) || cond_fail || (int'(step_idx) >= MAX_STEPS);

    always_comb begin
        strobes  = '0;
        addr_sel = ADDR_NONE;
        last     = 1'b0;
        if (!halt) begin
            strobes  = dec_strobes;
            addr_sel = dec_addr;
            last     = seq_last;
            if (seq_last) begin
                strobes.mem_to_ir = 1'b1;
                strobes.inc_pc    = 1'b1;
            end
            if (stall) strobes = strobes & STALL_KEEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_idx <= '0;
            halt     <= 1'b0;
        end else if (stall) begin
            step_idx <= step_idx;
            halt     <= halt;
        end else if (halt) begin
            step_idx <= '0;
            if (wake) halt <= 1'b0;
        end else begin
            step_idx <= seq_last ? '0 : step_idx + 1'b1;
            if (state == EX_HALT) halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_sequencer.sv
// tb/tb_ex_sequencer.sv - table-driven scoreboard bench for ex_sequencer.
module tb_ex_sequencer;
    import sm83_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ctl_op_t     ctl_op;
    alu_op_t     decoded_alu_op;
    logic        cond_met, mem_wait, wake;
    alu_op_t     alu_op;
    ctl_strobe_t strobes;
    addr_sel_t   addr_sel;
    logic [2:0]  step_idx;
    logic        last, halt;

    ex_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ctl_op(ctl_op), .decoded_alu_op(decoded_alu_op),
        .cond_met(cond_met), .mem_wait(mem_wait), .wake(wake), .alu_op(alu_op),
        .strobes(strobes), .addr_sel(addr_sel), .step_idx(step_idx), .last(last), .halt(halt)
    );

    always #5 clk = ~clk;

    localparam ctl_strobe_t S_0    = '0;
    localparam ctl_strobe_t S_INC  = '{inc_pc: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_WZPC = '{wz_to_pc: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_Z    = '{mem_to_z: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_W    = '{mem_to_w: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_IR   = '{mem_to_ir: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_CAP  = '{capture_alu_res: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_OP1  = '{r8_to_alu_op1: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_FLG  = '{update_flags: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_R8M  = '{r8_to_mem: 1'b1, default: 1'b0};
    localparam ctl_strobe_t S_ZM   = '{z_to_mem: 1'b1, default: 1'b0};

    typedef struct {
        ctl_op_t     op;
        logic        cond;
        logic        mwait;
        logic        wk;
        int          step;
        ctl_strobe_t stb;
        addr_sel_t   addr;
        logic        lst;
        logic        hlt;
    } vec_t;

    typedef struct {
        string       tag;
        int          step;
        ctl_strobe_t stb;
        addr_sel_t   addr;
        logic        lst;
        logic        hlt;
        alu_op_t     alu;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input ctl_op_t op, input logic cond, input logic mwait, input logic wk,
                       input int step, input ctl_strobe_t stb, input addr_sel_t addr,
                       input logic lst, input logic hlt);
        vec_t v;
        v.op = op; v.cond = cond; v.mwait = mwait; v.wk = wk; v.step = step;
        v.stb = stb; v.addr = addr; v.lst = lst; v.hlt = hlt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, ".step_idx"}, 32'(step_idx), 32'(e.step));
        chk({e.tag, ".strobes"}, 32'(strobes), 32'(e.stb));
        chk({e.tag, ".addr_sel"}, 32'(addr_sel), 32'(e.addr));
        chk({e.tag, ".last"}, 32'(last), 32'(e.lst));
        chk({e.tag, ".halt"}, 32'(halt), 32'(e.hlt));
        chk({e.tag, ".alu_op"}, 32'(alu_op), 32'(e.alu));
    endtask

    task automatic run_row(input vec_t v, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        ctl_op         = v.op;
        cond_met       = v.cond;
        mem_wait       = v.mwait;
        wake           = v.wk;
        decoded_alu_op = alu_op_t'(4'($urandom_range(0, 10)));
        e.tag = tag; e.step = v.step; e.stb = v.stb; e.addr = v.addr;
        e.lst = v.lst; e.hlt = v.hlt; e.alu = decoded_alu_op;
        exp_q.push_back(e);
        @(negedge clk);
        compare_head();
    endtask

    function automatic vec_t mk(input ctl_op_t op, input int step, input ctl_strobe_t stb,
                                input addr_sel_t addr, input logic lst, input logic hlt);
        vec_t v;
        v.op = op; v.cond = 1'b0; v.mwait = 1'b0; v.wk = 1'b0; v.step = step;
        v.stb = stb; v.addr = addr; v.lst = lst; v.hlt = hlt;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: op, cond, mem_wait, wake, step, strobes, addr_sel, last, halt
        add(CTL_NOP,       0, 0, 0, 0, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_LD_R8_D8,  0, 0, 0, 0, S_Z | S_INC, ADDR_PC, 0, 0);
        add(CTL_LD_R8_D8,  0, 0, 0, 1, S_CAP | S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_JP_CC_A16, 0, 0, 0, 0, S_Z | S_INC, ADDR_PC, 0, 0);
        add(CTL_JP_CC_A16, 0, 0, 0, 1, S_W | S_INC, ADDR_PC, 0, 0);
        add(CTL_JP_CC_A16, 0, 0, 0, 2, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_JP_CC_A16, 1, 0, 0, 0, S_Z | S_INC, ADDR_PC, 0, 0);
        add(CTL_JP_CC_A16, 1, 0, 0, 1, S_W | S_INC, ADDR_PC, 0, 0);
        add(CTL_JP_CC_A16, 1, 0, 0, 2, S_0, ADDR_PC, 0, 0);
        add(CTL_JP_CC_A16, 1, 0, 0, 3, S_WZPC, ADDR_NONE, 0, 0);
        add(CTL_JP_CC_A16, 1, 0, 0, 4, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_JR_CC_D8,  1, 0, 0, 0, S_Z | S_INC, ADDR_PC, 0, 0);
        add(CTL_JR_CC_D8,  1, 0, 0, 1, S_0, ADDR_PC, 0, 0);
        add(CTL_JR_CC_D8,  1, 0, 0, 2, S_OP1 | S_CAP | S_FLG, ADDR_PC, 0, 0);
        add(CTL_JR_CC_D8,  1, 0, 0, 3, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_JR_CC_D8,  0, 0, 0, 0, S_Z | S_INC, ADDR_PC, 0, 0);
        add(CTL_JR_CC_D8,  0, 0, 0, 1, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_LD_HL_D8,  0, 0, 0, 0, S_Z | S_INC, ADDR_PC, 0, 0);
        add(CTL_LD_HL_D8,  0, 0, 0, 1, S_ZM, ADDR_GP16, 0, 0);
        add(CTL_LD_HL_D8,  0, 0, 0, 2, S_IR | S_INC, ADDR_PC, 1, 0);
        add(ctl_op_t'(4'hC), 0, 0, 0, 0, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_LDPTR_A_A16, 0, 0, 0, 0, S_Z | S_INC, ADDR_PC, 0, 0);
`ifdef SEQ_STALL_EN
        for (int k = 0; k < 3; k++)
            add(CTL_LDPTR_A_A16, 0, 1, 0, 1, S_0, ADDR_PC, 0, 0);
        add(CTL_LDPTR_A_A16, 0, 0, 0, 1, S_W | S_INC, ADDR_PC, 0, 0);
        add(CTL_LDPTR_A_A16, 0, 0, 0, 2, S_R8M, ADDR_WZ, 0, 0);
        add(CTL_LDPTR_A_A16, 0, 0, 0, 3, S_IR | S_INC, ADDR_PC, 1, 0);
`else
        add(CTL_LDPTR_A_A16, 0, 1, 0, 1, S_W | S_INC, ADDR_PC, 0, 0);
        add(CTL_LDPTR_A_A16, 0, 1, 0, 2, S_R8M, ADDR_WZ, 0, 0);
        add(CTL_LDPTR_A_A16, 0, 1, 0, 3, S_IR | S_INC, ADDR_PC, 1, 0);
`endif
        // Halt entry, ten idle cycles, wake, then the fetched op runs; wake when running is ignored.
        add(CTL_HALT, 0, 0, 0, 0, S_IR | S_INC, ADDR_PC, 1, 0);
        for (int k = 0; k < 10; k++)
            add(CTL_NOP, 0, 0, 0, 0, S_0, ADDR_NONE, 0, 1);
        add(CTL_NOP, 0, 0, 1, 0, S_0, ADDR_NONE, 0, 1);
        add(CTL_NOP, 0, 0, 0, 0, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_NOP, 0, 0, 1, 0, S_IR | S_INC, ADDR_PC, 1, 0);
        add(CTL_NOP, 0, 0, 0, 0, S_IR | S_INC, ADDR_PC, 1, 0);

        rst_n = 1'b0; ctl_op = CTL_NOP; decoded_alu_op = ALU_ADD;
        cond_met = 1'b0; mem_wait = 1'b0; wake = 1'b0;
        #12;
        chk("reset.step_idx", 32'(step_idx), 32'd0);
        chk("reset.halt", 32'(halt), 32'd0);
        chk("reset.strobes", 32'(strobes), 32'(S_IR | S_INC));
        chk("reset.last", 32'(last), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_row(vecs[i], $sformatf("v%0d", i));

        // Asynchronous reset at step 2 of JP a16, then the instruction restarts from step 0.
        run_row(mk(CTL_JP_A16, 0, S_Z | S_INC, ADDR_PC, 0, 0), "jp.s0");
        run_row(mk(CTL_JP_A16, 1, S_W | S_INC, ADDR_PC, 0, 0), "jp.s1");
        @(posedge clk);
        #1;
        chk("jp.s2.step_idx", 32'(step_idx), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("jp.rst.step_idx", 32'(step_idx), 32'd0);
        chk("jp.rst.halt", 32'(halt), 32'd0);
        chk("jp.rst.strobes", 32'(strobes), 32'(S_Z | S_INC));
        @(negedge clk);
        rst_n = 1'b1;
        run_row(mk(CTL_JP_A16, 1, S_W | S_INC, ADDR_PC, 0, 0), "jp.r1");
        run_row(mk(CTL_JP_A16, 2, S_WZPC, ADDR_NONE, 0, 0), "jp.r2");
        run_row(mk(CTL_JP_A16, 3, S_IR | S_INC, ADDR_PC, 1, 0), "jp.r3");

        // Asynchronous reset while halted.
        run_row(mk(CTL_HALT, 0, S_IR | S_INC, ADDR_PC, 1, 0), "hr.enter");
        run_row(mk(CTL_NOP, 0, S_0, ADDR_NONE, 0, 1), "hr.halted");
        @(posedge clk);
        #1;
        chk("hr.pre.halt", 32'(halt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("hr.rst.halt", 32'(halt), 32'd0);
        chk("hr.rst.step_idx", 32'(step_idx), 32'd0);
        chk("hr.rst.last", 32'(last), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_row(mk(CTL_NOP, 0, S_IR | S_INC, ADDR_PC, 1, 0), "hr.after");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
